apb_mig_bridge: RTL and testbench

- APB4 slave that turns single 32-bit APB reads/writes into Xilinx MIG user-interface (UI) commands.
- Sits directly downstream of the APB slave modport and drives the MIG app_* port.
- One transfer in flight at a time.
- Runs entirely on the APB clock; the MIG UI is clocked by the same clock, and any CDC lives outside this block.

---
 rtl/apb_mig_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_apb_mig_bridge.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_mig_bridge.sv
// apb_mig_bridge: APB4 slave turning single 32-bit accesses into Xilinx MIG UI commands.
// Optional read-data timeout is enabled by defining APB_MIG_RD_TIMEOUT_EN.
module apb_mig_bridge #(
  parameter int unsigned     APB_ADDR_W     = 32,
  parameter int unsigned     APB_DATA_W     = 32,
  parameter int unsigned     MIG_ADDR_W     = 28,
  parameter int unsigned     MIG_DATA_W     = 128,
  parameter longint unsigned MEM_BYTES      = 64'd1 << 28,
  parameter int unsigned     TIMEOUT_CYCLES = 1024
) (
  input  logic                      pclk_i,
  input  logic                      preset_n,
  input  logic [APB_ADDR_W-1:0]     paddr_i,
  input  logic [APB_DATA_W-1:0]     pwdata_i,
  input  logic                      pwrite_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic [APB_DATA_W/8-1:0]   pstrb_i,
  output logic [APB_DATA_W-1:0]     prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  input  logic                      init_calib_complete_i,
  output logic [MIG_ADDR_W-1:0]     app_addr_o,
  output logic [2:0]                app_cmd_o,
  output logic                      app_en_o,
  input  logic                      app_rdy_i,
  output logic [MIG_DATA_W-1:0]     app_wdf_data_o,
  output logic [MIG_DATA_W/8-1:0]   app_wdf_mask_o,
  output logic                      app_wdf_wren_o,
  output logic                      app_wdf_end_o,
  input  logic                      app_wdf_rdy_i,
  input  logic [MIG_DATA_W-1:0]     app_rd_data_i,
  input  logic                      app_rd_data_valid_i
);

  localparam int unsigned STRB_W   = APB_DATA_W / 8;
  localparam int unsigned LANES    = MIG_DATA_W / APB_DATA_W;
  localparam int unsigned LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned LANE_LSB = $clog2(STRB_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_CMD,
    S_RD_WAIT,
    S_RESP,
    S_ERR
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [MIG_ADDR_W-1:0]   r_app_addr;
  logic [MIG_DATA_W-1:0]   r_wdf_data;
  logic [MIG_DATA_W/8-1:0] r_wdf_mask;
  logic [LANE_W-1:0]       r_lane;
  logic [APB_DATA_W-1:0]   r_rdata;
  logic                    r_cmd_done;
  logic                    r_wdf_done;
  logic                    r_abort;

  logic                    w_setup;
  logic                    w_start;
  logic                    w_err;
  logic                    w_apb_live;
  logic                    w_cmd_hs;
  logic                    w_wdf_hs;
  logic                    w_rd_capture;
  logic                    w_drop_nz;
  logic                    w_timeout;
  logic [LANE_W-1:0]       w_lane_in;
  logic [MIG_DATA_W-1:0]   w_wdata;
  logic [MIG_DATA_W/8-1:0] w_mask;
  logic [APB_DATA_W-1:0]   w_rd_lane;

  assign w_setup      = psel_i & ~penable_i;
  assign w_start      = (r_state == S_IDLE) & w_setup;
  assign w_err        = (64'(paddr_i) >= MEM_BYTES) | ~init_calib_complete_i;
  assign w_apb_live   = psel_i & penable_i & ~r_abort;
  assign w_cmd_hs     = app_en_o & app_rdy_i;
  assign w_wdf_hs     = app_wdf_wren_o & app_wdf_rdy_i;
  assign w_rd_capture = (r_state == S_RD_WAIT) & app_rd_data_valid_i & ~w_drop_nz;
  assign w_lane_in    = LANE_W'((paddr_i >> LANE_LSB) & (LANES - 1));

  assign prdata_o       = r_rdata;
  assign app_addr_o     = r_app_addr;
  assign app_wdf_data_o = r_wdf_data;
  assign app_wdf_mask_o = r_wdf_mask;
  assign app_wdf_end_o  = app_wdf_wren_o;

`ifdef APB_MIG_RD_TIMEOUT_EN
  localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned DROP_W = 8;

  logic [TMO_W-1:0]  r_tmo;
  logic [DROP_W-1:0] r_drop;

  assign w_drop_nz = (r_drop != '0);
  assign w_timeout = (r_state == S_RD_WAIT) & ~app_rd_data_valid_i &
                     (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  // Each timed-out read leaves one beat still owed by the MIG; the drop counter swallows it.
  always_ff @(posedge pclk_i) begin
    if (!preset_n) begin
      r_tmo  <= '0;
      r_drop <= '0;
    end else begin
      r_tmo <= (r_state == S_RD_WAIT) ? r_tmo + 1'b1 : '0;
      if (w_timeout && (r_drop != '1))
        r_drop <= r_drop + 1'b1;
      else if (app_rd_data_valid_i && w_drop_nz)
        r_drop <= r_drop - 1'b1;
    end
  end
`else
  logic w_unused_tmo;

  assign w_drop_nz    = 1'b0;
  assign w_timeout    = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    w_wdata = '0;
    w_mask  = '1;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_wdata[i*APB_DATA_W +: APB_DATA_W] = pwdata_i;
      if (LANE_W'(i) == w_lane_in)
        w_mask[i*STRB_W +: STRB_W] = ~pstrb_i;
    end
  end

  always_comb begin
    w_rd_lane = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (LANE_W'(i) == r_lane)
        w_rd_lane = app_rd_data_i[i*APB_DATA_W +: APB_DATA_W];
    end
  end

  always_ff @(posedge pclk_i) begin
    if (!preset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    app_en_o       = 1'b0;
    app_cmd_o      = 3'b000;
    app_wdf_wren_o = 1'b0;
    pready_o       = 1'b0;
    pslverr_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_setup)
          w_next = w_err ? S_ERR : (pwrite_i ? S_WR : S_RD_CMD);
      end
      S_WR: begin
        // Command and data channels retire independently; leave once both are accepted.
        app_en_o       = ~r_cmd_done;
        app_wdf_wren_o = ~r_wdf_done;
        if ((r_cmd_done | app_rdy_i) & (r_wdf_done | app_wdf_rdy_i))
          w_next = S_RESP;
      end
      S_RD_CMD: begin
        app_en_o  = 1'b1;
        app_cmd_o = 3'b001;
        if (app_rdy_i)
          w_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (w_rd_capture)
          w_next = S_RESP;
        else if (w_timeout)
          w_next = S_ERR;
      end
      S_RESP: begin
        pready_o = w_apb_live;
        w_next   = S_IDLE;
      end
      S_ERR: begin
        pready_o  = w_apb_live;
        pslverr_o = w_apb_live;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (!preset_n) begin
      r_app_addr <= '0;
      r_wdf_data <= '0;
      r_wdf_mask <= '0;
      r_lane     <= '0;
      r_rdata    <= '0;
      r_cmd_done <= 1'b0;
      r_wdf_done <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      if (w_start) begin
        r_app_addr <= {paddr_i[MIG_ADDR_W:4], 3'b000};
        r_wdf_data <= w_wdata;
        r_wdf_mask <= w_mask;
        r_lane     <= w_lane_in;
        r_rdata    <= '0;
        r_cmd_done <= 1'b0;
        r_wdf_done <= 1'b0;
      end else begin
        if (w_cmd_hs)
          r_cmd_done <= 1'b1;
        if (w_wdf_hs)
          r_wdf_done <= 1'b1;
      end
      if (w_rd_capture)
        r_rdata <= w_rd_lane;
      // A master that lets psel go mid-transfer gets no pready for it.
      r_abort <= (r_state == S_IDLE) ? 1'b0 : (r_abort | ~psel_i);
    end
  end

endmodule

// File: tb/tb_apb_mig_bridge.sv
// Self-checking bench for apb_mig_bridge: directed cases plus randomized APB traffic
// checked against a cycle-count/lane-arithmetic reference model.
module tb_apb_mig_bridge;

  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         preset_n;
  logic [31:0]  paddr;
  logic [31:0]  pwdata;
  logic         pwrite;
  logic         psel;
  logic         penable;
  logic [3:0]   pstrb;
  logic [31:0]  prdata;
  logic         pready;
  logic         pslverr;
  logic         calib;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] wdf_data;
  logic [15:0]  wdf_mask;
  logic         wdf_wren;
  logic         wdf_end;
  logic         wdf_rdy;
  logic [127:0] rd_data;
  logic         rd_valid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  apb_mig_bridge #(
    .APB_ADDR_W     (32),
    .APB_DATA_W     (32),
    .MIG_ADDR_W     (28),
    .MIG_DATA_W     (128),
    .MEM_BYTES      (64'd1 << 28),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .pclk_i                (clk),
    .preset_n              (preset_n),
    .paddr_i               (paddr),
    .pwdata_i              (pwdata),
    .pwrite_i              (pwrite),
    .psel_i                (psel),
    .penable_i             (penable),
    .pstrb_i               (pstrb),
    .prdata_o              (prdata),
    .pready_o              (pready),
    .pslverr_o             (pslverr),
    .init_calib_complete_i (calib),
    .app_addr_o            (app_addr),
    .app_cmd_o             (app_cmd),
    .app_en_o              (app_en),
    .app_rdy_i             (app_rdy),
    .app_wdf_data_o        (wdf_data),
    .app_wdf_mask_o        (wdf_mask),
    .app_wdf_wren_o        (wdf_wren),
    .app_wdf_end_o         (wdf_end),
    .app_wdf_rdy_i         (wdf_rdy),
    .app_rd_data_i         (rd_data),
    .app_rd_data_valid_i   (rd_valid)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One APB transfer with the bench acting as the MIG. cw/ww: cycles app_rdy/wdf_rdy are
  // withheld; rl: cycles from command acceptance to read data; stale: extra beat first in
  // RD_WAIT (owed from an earlier timeout); tmo: no read data at all.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input bit cal, input int cw, input int ww,
                      input int rl, input logic [127:0] rword, input bit stale, input bit tmo);
    bit           err;
    int           lane;
    int           last;
    logic [15:0]  emask;
    logic [127:0] edata;
    logic [31:0]  erd;
    err  = (addr >= 32'h1000_0000) || !cal;
    lane = (addr / 4) % 4;
    if (err)       last = 1;
    else if (wr)   last = ((cw > ww) ? cw : ww) + 2;
    else if (tmo)  last = cw + TMO + 2;
    else           last = cw + rl + 2 + (stale ? 1 : 0);
    for (int b = 0; b < 16; b++)
      emask[b] = !(((b / 4) == lane) && st[b % 4]);
    for (int l = 0; l < 4; l++)
      edata[32*l +: 32] = wd;
    erd = (wr || err || tmo) ? 32'h0 : 32'(rword >> (32 * lane));

    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd; pstrb = st; calib = cal;
    @(negedge clk);
    penable = 1'b1;
    for (int k = 1; k <= last; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (k == 1 && !err) begin
        check("app_addr", app_addr, (addr >> 1) & 32'hFFFF_FFF8);
        check("app_cmd", app_cmd, wr ? 3'b000 : 3'b001);
        if (wr) begin
          check("wdf_mask", wdf_mask, emask);
          check("wdf_data", wdf_data, edata);
        end
      end
      check("app_en", app_en, !err && (k <= cw + 1));
      check("wdf_wren", wdf_wren, wr && !err && (k <= ww + 1));
      check("wdf_end", wdf_end, wr && !err && (k <= ww + 1));
      check("pready", pready, k == last);
      if (k == last) begin
        check("pslverr", pslverr, err || tmo);
        check("prdata", prdata, erd);
      end
      app_rdy  = (k >= cw + 1);
      wdf_rdy  = (k >= ww + 1);
      rd_valid = 1'b0;
      rd_data  = {$urandom, $urandom, $urandom, $urandom};
      if (!wr && !err && !tmo) begin
        if (stale && k == cw + 2) begin
          rd_valid = 1'b1;
          rd_data  = ~rword;
        end else if (k == cw + 1 + rl + (stale ? 1 : 0)) begin
          rd_valid = 1'b1;
          rd_data  = rword;
        end
      end
    end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; app_rdy = 1'b0; wdf_rdy = 1'b0; rd_valid = 1'b0; calib = 1'b1;
    #1;
    check("pready_after", pready, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] w;
    preset_n = 1'b0; paddr = '0; pwdata = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;
    pstrb = '0; calib = 1'b1; app_rdy = 1'b0; wdf_rdy = 1'b0; rd_data = '0; rd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_apb", {prdata, pready, pslverr}, '0);
    check("reset_app", {app_addr, app_cmd, app_en, wdf_wren, wdf_end, wdf_mask}, '0);
    check("reset_wdata", wdf_data, '0);
    preset_n = 1'b1;

    xfer(1, 32'h0000_0014, 32'hDEAD_BEEF, 4'hF, 1, 0, 0, 1, '0, 0, 0);
    w = 128'h0;
    w[95:64] = 32'hCAFE_F00D;
    xfer(0, 32'h0000_0018, 32'h0, 4'h0, 1, 0, 0, 2, w, 0, 0);
    xfer(1, 32'h0000_0104, 32'h1234_5678, 4'h5, 1, 5, 2, 1, '0, 0, 0);
    xfer(0, 32'h1000_0000, 32'h0, 4'h0, 1, 0, 0, 1, '1, 0, 0);
    xfer(1, 32'h0000_0020, 32'hA5A5_A5A5, 4'hF, 0, 0, 0, 1, '0, 0, 0);

    // Reset while waiting for read data, then a stale beat lands in IDLE.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = 32'h0000_0018; pwrite = 1'b0; pwdata = 32'h5555_AAAA;
    @(negedge clk);
    penable = 1'b1; app_rdy = 1'b1;
    @(negedge clk);
    app_rdy = 1'b0; preset_n = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_apb", {prdata, pready, pslverr}, '0);
    check("rst_mid_app", {app_addr, app_cmd, app_en, wdf_wren, wdf_end, wdf_mask}, '0);
    check("rst_mid_wdata", wdf_data, '0);
    preset_n = 1'b1;
    @(negedge clk);
    rd_valid = 1'b1; rd_data = {4{32'hBAD0_BAD0}};
    @(negedge clk);
    rd_valid = 1'b0;
    #1;
    check("stale_pready", pready, 1'b0);
    xfer(0, 32'h0000_0018, 32'h0, 4'h0, 1, 1, 0, 1, {$urandom, $urandom, $urandom, $urandom}, 0, 0);

`ifdef APB_MIG_RD_TIMEOUT_EN
    xfer(0, 32'h0000_0024, 32'h0, 4'h0, 1, 0, 0, 1, '0, 0, 1);
    xfer(0, 32'h0000_0028, 32'h0, 4'h0, 1, 1, 0, 2, {$urandom, $urandom, $urandom, $urandom}, 1, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      bit          rwr;
      logic [31:0] ra;
      ra  = ($urandom % 8 == 0) ? $urandom : ($urandom & 32'h0FFF_FFFF);
      rwr = $urandom % 2;
      xfer(rwr, ra, $urandom, 4'($urandom), ($urandom % 10) != 0,
           int'($urandom % 4), int'($urandom % 4), 1 + int'($urandom % 5),
           {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
